forward_mix_output: RTL and testbench

- Return path of the forward mix layer. Takes the wide (N_LEN) result matrix the mix layer produces at the end of each of the three forward mix passes.
- Narrows each element to the stored N_LEN_W format with signed saturation.
- Latches the result into a per-pass holding bank (F_MIX1/F_MIX2/F_MIX3) so the next stage (tanh, next mix input, output head) reads a stable narrow matrix.
- Pulses a per-pass valid and keeps saturation statistics for training diagnostics.

---
 rtl/forward_mix_output.sv | 129 ++++++++++++
 tb/tb_forward_mix_output.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/forward_mix_output.sv
// forward_mix_output: narrows the wide mix-layer result with signed saturation
// and latches it into the bank of the current forward mix pass.
module forward_mix_output #(
   parameter int HID_DIM   = 24,
   parameter int N_LEN     = 16,
   parameter int N_LEN_W   = 12,
   parameter int STATE_LEN = 4,
   parameter int CNT_LEN   = 16,
   parameter logic [STATE_LEN-1:0] F_MIX1 = STATE_LEN'(3),
   parameter logic [STATE_LEN-1:0] F_MIX2 = STATE_LEN'(4),
   parameter logic [STATE_LEN-1:0] F_MIX3 = STATE_LEN'(5)
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [STATE_LEN-1:0]               state,
   input  logic                               valid_in,
   input  logic [HID_DIM*HID_DIM*N_LEN-1:0]   d,
   input  logic                               clr_sat,
   output logic [HID_DIM*HID_DIM*N_LEN_W-1:0] q_mix1,
   output logic [HID_DIM*HID_DIM*N_LEN_W-1:0] q_mix2,
   output logic [HID_DIM*HID_DIM*N_LEN_W-1:0] q_mix3,
   output logic                               valid_mix1,
   output logic                               valid_mix2,
   output logic                               valid_mix3,
   output logic                               sat_flag,
   output logic [CNT_LEN-1:0]                 sat_cnt
);

   localparam int NE    = HID_DIM * HID_DIM;
   localparam int HW    = N_LEN - N_LEN_W + 1;
   localparam int POP_W = $clog2(NE + 1);
   localparam logic [N_LEN_W-1:0] MAX_W = {1'b0, {(N_LEN_W-1){1'b1}}};
   localparam logic [N_LEN_W-1:0] MIN_W = {1'b1, {(N_LEN_W-1){1'b0}}};

   typedef enum logic [1:0] {
      TAG_NONE,
      TAG_MIX1,
      TAG_MIX2,
      TAG_MIX3
   } tag_t;

   tag_t                   tag_d;
   tag_t                   s1_tag;
   logic                   s1_valid;
   logic [NE*N_LEN-1:0]    s1_d;
   logic [NE*N_LEN_W-1:0]  nar;
   logic [NE-1:0]          sat;
   logic [POP_W-1:0]       pop;
   logic [CNT_LEN:0]       sum;
   logic                   wr;

   always_comb begin
      tag_d = TAG_NONE;
      unique case (1'b1)
         state == F_MIX1: tag_d = TAG_MIX1;
         state == F_MIX2: tag_d = TAG_MIX2;
         state == F_MIX3: tag_d = TAG_MIX3;
         default: tag_d = TAG_NONE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_tag   <= TAG_NONE;
         s1_d     <= '0;
      end else begin
         s1_valid <= valid_in;
         if (valid_in) begin
            s1_tag <= tag_d;
            s1_d   <= d;
         end
      end
   end

   // In range when the bits above the narrow sign bit match it; the
   // fraction is kept as-is, mirroring the input-side sign extension.
   for (genvar e = 0; e < NE; e++) begin : g_nar
      logic [N_LEN-1:0] x;
      logic [HW-1:0]    hi;
      logic             in_rng;
      assign x      = s1_d[e*N_LEN +: N_LEN];
      assign hi     = x[N_LEN-1 -: HW];
      assign in_rng = (&hi) | ~(|hi);
      assign sat[e] = ~in_rng;
      assign nar[e*N_LEN_W +: N_LEN_W] =
         in_rng     ? x[N_LEN_W-1:0] :
         x[N_LEN-1] ? MIN_W : MAX_W;
   end

   always_comb begin
      pop = '0;
      for (int e = 0; e < NE; e++)
         pop = pop + POP_W'(sat[e]);
   end

   assign wr  = s1_valid && (s1_tag != TAG_NONE);
   assign sum = {1'b0, sat_cnt} + (CNT_LEN+1)'(pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         q_mix1     <= '0;
         q_mix2     <= '0;
         q_mix3     <= '0;
         valid_mix1 <= 1'b0;
         valid_mix2 <= 1'b0;
         valid_mix3 <= 1'b0;
      end else begin
         valid_mix1 <= s1_valid && (s1_tag == TAG_MIX1);
         valid_mix2 <= s1_valid && (s1_tag == TAG_MIX2);
         valid_mix3 <= s1_valid && (s1_tag == TAG_MIX3);
         if (s1_valid && (s1_tag == TAG_MIX1)) q_mix1 <= nar;
         if (s1_valid && (s1_tag == TAG_MIX2)) q_mix2 <= nar;
         if (s1_valid && (s1_tag == TAG_MIX3)) q_mix3 <= nar;
      end
   end

   // A clear in the same cycle as a write discards that write's saturations.
   always_ff @(posedge clk) begin
      if (rst || clr_sat) begin
         sat_cnt  <= '0;
         sat_flag <= 1'b0;
      end else if (wr) begin
         sat_cnt <= sum[CNT_LEN] ? {CNT_LEN{1'b1}} : sum[CNT_LEN-1:0];
         if (pop != '0) sat_flag <= 1'b1;
      end
   end

endmodule

// File: tb/tb_forward_mix_output.sv
// tb_forward_mix_output: directed checks of narrowing, bank routing,
// pipeline timing, saturation statistics and reset behaviour.
module tb_forward_mix_output;

   localparam int HID = 24;
   localparam int NE  = HID * HID;
   localparam int ND  = NE * 16;
   localparam int NQ  = NE * 12;
   localparam logic [3:0] S_IDLE = 4'd0;
   localparam logic [3:0] S_MIX1 = 4'd3;
   localparam logic [3:0] S_MIX2 = 4'd4;
   localparam logic [3:0] S_MIX3 = 4'd5;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    state;
   logic          valid_in;
   logic [ND-1:0] d;
   logic          clr_sat;
   logic [NQ-1:0] q_mix1, q_mix2, q_mix3;
   logic          valid_mix1, valid_mix2, valid_mix3;
   logic          sat_flag;
   logic [15:0]   sat_cnt;

   int total = 0;
   int bad   = 0;

   logic [NQ-1:0] e1, e2, e3;

   forward_mix_output dut (
      .clk        (clk),
      .rst        (rst),
      .state      (state),
      .valid_in   (valid_in),
      .d          (d),
      .clr_sat    (clr_sat),
      .q_mix1     (q_mix1),
      .q_mix2     (q_mix2),
      .q_mix3     (q_mix3),
      .valid_mix1 (valid_mix1),
      .valid_mix2 (valid_mix2),
      .valid_mix3 (valid_mix3),
      .sat_flag   (sat_flag),
      .sat_cnt    (sat_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [ND-1:0] rep16(input logic [15:0] v);
      logic [ND-1:0] r;
      for (int e = 0; e < NE; e++) r[e*16 +: 16] = v;
      return r;
   endfunction

   function automatic logic [NQ-1:0] rep12(input logic [11:0] v);
      logic [NQ-1:0] r;
      for (int e = 0; e < NE; e++) r[e*12 +: 12] = v;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_bank(input string tag, input logic [NQ-1:0] obs,
                           input logic [NQ-1:0] exp);
      int idx;
      idx = 0;
      for (int e = NE - 1; e >= 0; e--)
         if (obs[e*12 +: 12] !== exp[e*12 +: 12]) idx = e;
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s elem=%0d obs=%h exp=%h", tag, idx,
                obs[idx*12 +: 12], exp[idx*12 +: 12]);
      end
   endtask

   function automatic logic [31:0] vm();
      return {29'd0, valid_mix3, valid_mix2, valid_mix1};
   endfunction

   initial begin
      rst = 1'b1; state = S_IDLE; valid_in = 1'b0;
      d = '0; clr_sat = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk_bank("rst_q1", q_mix1, '0);
      chk_bank("rst_q2", q_mix2, '0);
      chk_bank("rst_q3", q_mix3, '0);
      chk("rst_valid", vm(), 32'd0);
      chk("rst_cnt", {16'd0, sat_cnt}, 32'd0);
      chk("rst_flag", {31'd0, sat_flag}, 32'd0);

      // pass 1, in range: 1.5 everywhere
      state = S_MIX1; d = rep16(16'h0180); valid_in = 1'b1;
      tick();
      valid_in = 1'b0; state = S_IDLE;
      chk("p1_early", vm(), 32'd0);
      tick();
      e1 = rep12(12'h180); e2 = '0; e3 = '0;
      chk("p1_valid", vm(), 32'd1);
      chk_bank("p1_q1", q_mix1, e1);
      chk_bank("p1_q2", q_mix2, e2);
      chk_bank("p1_q3", q_mix3, e3);
      chk("p1_cnt", {16'd0, sat_cnt}, 32'd0);
      tick();
      chk("p1_pulse_end", vm(), 32'd0);
      chk_bank("p1_hold", q_mix1, e1);

      // pass 2, saturation both directions plus in-range negative
      d = '0;
      d[0 +: 16] = 16'h0900; d[16 +: 16] = 16'hF700; d[32 +: 16] = 16'hF880;
      state = S_MIX2; valid_in = 1'b1;
      tick();
      valid_in = 1'b0; state = S_IDLE;
      tick();
      e2 = '0;
      e2[0 +: 12] = 12'h7FF; e2[12 +: 12] = 12'h800; e2[24 +: 12] = 12'h880;
      chk("p2_valid", vm(), 32'd2);
      chk_bank("p2_q2", q_mix2, e2);
      chk_bank("p2_q1", q_mix1, e1);
      chk("p2_cnt", {16'd0, sat_cnt}, 32'd2);
      chk("p2_flag", {31'd0, sat_flag}, 32'd1);

      // back-to-back MIX1 then MIX3
      state = S_MIX1; d = rep16(16'h0080); valid_in = 1'b1;
      tick();
      state = S_MIX3; d = rep16(16'hFF00);
      tick();
      valid_in = 1'b0; state = S_IDLE;
      e1 = rep12(12'h080); e3 = rep12(12'hF00);
      chk("b2b_v1", vm(), 32'd1);
      chk_bank("b2b_q1", q_mix1, e1);
      tick();
      chk("b2b_v3", vm(), 32'd4);
      chk_bank("b2b_q3", q_mix3, e3);
      chk_bank("b2b_q1_hold", q_mix1, e1);
      chk_bank("b2b_q2_hold", q_mix2, e2);
      chk("b2b_cnt", {16'd0, sat_cnt}, 32'd2);

      // ignored tag: no write, no pulse, counters unchanged
      state = S_IDLE; d = rep16(16'h7FFF); valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      tick();
      chk("idle_valid", vm(), 32'd0);
      tick();
      chk("idle_valid2", vm(), 32'd0);
      chk_bank("idle_q1", q_mix1, e1);
      chk_bank("idle_q2", q_mix2, e2);
      chk_bank("idle_q3", q_mix3, e3);
      chk("idle_cnt", {16'd0, sat_cnt}, 32'd2);

      // saturating MIX3 write colliding with clr_sat
      state = S_MIX3; d = rep16(16'h1000); valid_in = 1'b1;
      tick();
      valid_in = 1'b0; state = S_IDLE; clr_sat = 1'b1;
      tick();
      clr_sat = 1'b0;
      e3 = rep12(12'h7FF);
      chk("clr_valid", vm(), 32'd4);
      chk_bank("clr_q3", q_mix3, e3);
      chk("clr_cnt", {16'd0, sat_cnt}, 32'd0);
      chk("clr_flag", {31'd0, sat_flag}, 32'd0);

      // counter clamp: 114 beats x 576 saturations exceeds 0xFFFF
      state = S_MIX2; d = rep16(16'h8000); valid_in = 1'b1;
      for (int b = 0; b < 114; b++) tick();
      valid_in = 1'b0; state = S_IDLE;
      tick();
      e2 = rep12(12'h800);
      chk("clamp_valid", vm(), 32'd2);
      chk_bank("clamp_q2", q_mix2, e2);
      chk("clamp_cnt", {16'd0, sat_cnt}, 32'h0000FFFF);
      chk("clamp_flag", {31'd0, sat_flag}, 32'd1);

      // reset while a beat is in flight
      state = S_MIX1; d = rep16(16'h0100); valid_in = 1'b1;
      tick();
      valid_in = 1'b0; state = S_IDLE; rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_valid", vm(), 32'd0);
      chk_bank("mid_q1", q_mix1, '0);
      chk_bank("mid_q2", q_mix2, '0);
      chk_bank("mid_q3", q_mix3, '0);
      chk("mid_cnt", {16'd0, sat_cnt}, 32'd0);
      tick();
      chk("mid_valid2", vm(), 32'd0);
      chk_bank("mid_q1_2", q_mix1, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
